// File: rtl/wb_regfile_sb.sv
// wb_regfile_sb
//   Register file with an integrated write-back scoreboard. Writes arrive on
//   the MEM/WB bus; two combinational source reads serve ID with same-cycle
//   bypass. A small pending-write counter per register drives a stall to ID
//   while any source register still has a write-back outstanding.
//
// Ports
//   clk                     system clock, rising edge
//   rst                     asynchronous reset, active low
//   wb_we/wb_addr/wb_data   write-back bus
//   re1/raddr1 -> rdata1    source port 1 (combinational)
//   re2/raddr2 -> rdata2    source port 2 (combinational)
//   issue_we/issue_addr     destination of the instruction issuing at ID
//   stall                   a requested source is pending (combinational)
//   err                     sticky counter overflow/underflow flag
module wb_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              stall,
    output logic              err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [CNT_W-1:0]  cnt  [NUM_REGS];

    logic                inc;
    logic                dec;
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic                err_set;
    logic                hazard1;
    logic                hazard2;

    function automatic logic [DATA_W-1:0] read_port(
        input logic              re,
        input logic [ADDR_W-1:0] raddr
    );
        if (!re || raddr == '0)
            return '0;
        else if (wb_we && wb_addr == raddr)
            return wb_data;
        else
            return regs[raddr];
    endfunction

    // A count of one that is being retired this cycle is not a hazard: the
    // operand comes straight off the write-back bus through the bypass.
    function automatic logic port_hazard(
        input logic              re,
        input logic [ADDR_W-1:0] raddr
    );
        logic retiring;
        retiring = dec && (wb_addr == raddr) && (cnt[raddr] == CNT_W'(1));
        return re && (raddr != '0) && (cnt[raddr] != '0) && !retiring;
    endfunction

    always_comb begin
        rdata1  = '0;
        rdata2  = '0;
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        if (rst) begin
            rdata1  = read_port(re1, raddr1);
            rdata2  = read_port(re2, raddr2);
            hazard1 = port_hazard(re1, raddr1);
            hazard2 = port_hazard(re2, raddr2);
        end
        stall = hazard1 | hazard2;
    end

    // inc/dec are never asserted for register 0, so cnt[0] stays at zero.
    assign inc = issue_we && !stall && (issue_addr != '0);
    assign dec = wb_we && (wb_addr != '0);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        err_set = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc_vec[i] = inc && (issue_addr == ADDR_W'(i));
            dec_vec[i] = dec && (wb_addr == ADDR_W'(i));
            if (inc_vec[i] && !dec_vec[i] && cnt[i] == CNT_MAX)
                err_set = 1'b1;
            if (dec_vec[i] && !inc_vec[i] && cnt[i] == '0)
                err_set = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
            err <= 1'b0;
        end else begin
            if (dec)
                regs[wb_addr] <= wb_data;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (inc_vec[i] && !dec_vec[i] && cnt[i] != CNT_MAX)
                    cnt[i] <= cnt[i] + CNT_W'(1);
                else if (dec_vec[i] && !inc_vec[i] && cnt[i] != '0)
                    cnt[i] <= cnt[i] - CNT_W'(1);
            end
            if (err_set)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_regfile_sb.sv
module tb_wb_regfile_sb;

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        issue_we;
    logic [4:0]  issue_addr;
    logic        stall;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    wb_regfile_sb dut (
        .clk        (clk),
        .rst        (rst),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .re1        (re1),
        .raddr1     (raddr1),
        .rdata1     (rdata1),
        .re2        (re2),
        .raddr2     (raddr2),
        .rdata2     (rdata2),
        .issue_we   (issue_we),
        .issue_addr (issue_addr),
        .stall      (stall),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        wb_we = 0; wb_addr = 0; wb_data = 0;
        re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
        issue_we = 0; issue_addr = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        step();
        step();
        rst = 1;
    endtask

    initial begin
        rst = 0;
        idle();
        // reset: outputs forced low even with a read requested
        re1 = 1; raddr1 = 5;
        settle();
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        step();
        step();
        rst = 1;
        settle();
        chk("post_rst_rdata1", rdata1, 32'h0);
        chk("post_rst_stall", {31'b0, stall}, 32'h0);
        chk("post_rst_err", {31'b0, err}, 32'h0);

        // write then read from the array
        idle();
        wb_we = 1; wb_addr = 3; wb_data = 32'hDEADBEEF;
        step();
        idle();
        re1 = 1; raddr1 = 3;
        settle();
        chk("rd_r3", rdata1, 32'hDEADBEEF);
        re1 = 0;
        settle();
        chk("rd_re_off", rdata1, 32'h0);

        // x0 is never written nor bypassed
        idle();
        wb_we = 1; wb_addr = 0; wb_data = 32'h1234;
        re2 = 1; raddr2 = 0;
        settle();
        chk("x0_bypass", rdata2, 32'h0);
        step();
        wb_we = 0;
        settle();
        chk("x0_read", rdata2, 32'h0);

        // same-cycle bypass, then array
        idle();
        wb_we = 1; wb_addr = 7; wb_data = 32'hA5A5A5A5;
        re2 = 1; raddr2 = 7;
        settle();
        chk("byp_rdata2", rdata2, 32'hA5A5A5A5);
        chk("byp_stall", {31'b0, stall}, 32'h0);
        step();
        wb_we = 0;
        settle();
        chk("arr_rdata2", rdata2, 32'hA5A5A5A5);

        // hazard on r9; second issue while stalled is dropped
        do_reset();
        issue_we = 1; issue_addr = 9;
        step();
        re1 = 1; raddr1 = 9;
        settle();
        chk("haz_c1", {31'b0, stall}, 32'h1);
        step();
        issue_we = 0;
        settle();
        chk("haz_c2", {31'b0, stall}, 32'h1);
        step();
        wb_we = 1; wb_addr = 9; wb_data = 32'h00000099;
        settle();
        chk("haz_c3_stall", {31'b0, stall}, 32'h0);
        chk("haz_c3_data", rdata1, 32'h00000099);
        step();
        wb_we = 0;
        settle();
        chk("haz_clear", {31'b0, stall}, 32'h0);
        chk("haz_err", {31'b0, err}, 32'h0);

        // three in flight, fourth overflows and holds at max
        do_reset();
        issue_we = 1; issue_addr = 4;
        step();
        step();
        step();
        settle();
        chk("ovf_before", {31'b0, err}, 32'h0);
        step();
        issue_we = 0;
        settle();
        chk("ovf_err", {31'b0, err}, 32'h1);
        re1 = 1; raddr1 = 4;
        settle();
        chk("mf_stall0", {31'b0, stall}, 32'h1);
        wb_we = 1; wb_addr = 4; wb_data = 32'h1;
        settle();
        chk("mf_wb1", {31'b0, stall}, 32'h1);
        step();
        wb_data = 32'h2;
        settle();
        chk("mf_wb2", {31'b0, stall}, 32'h1);
        step();
        wb_data = 32'h3;
        settle();
        chk("mf_wb3", {31'b0, stall}, 32'h0);
        chk("mf_wb3_data", rdata1, 32'h3);
        step();
        wb_we = 0;
        settle();
        chk("mf_done", {31'b0, stall}, 32'h0);

        // simultaneous inc/dec on r6 keeps count at 1
        do_reset();
        issue_we = 1; issue_addr = 6;
        step();
        wb_we = 1; wb_addr = 6; wb_data = 32'h66;
        step();
        idle();
        re1 = 1; raddr1 = 6;
        settle();
        chk("sim_stall", {31'b0, stall}, 32'h1);
        wb_we = 1; wb_addr = 6; wb_data = 32'h67;
        settle();
        chk("sim_retire", {31'b0, stall}, 32'h0);
        step();
        wb_we = 0;
        settle();
        chk("sim_done", {31'b0, stall}, 32'h0);
        chk("sim_err", {31'b0, err}, 32'h0);

        // underflow: write still commits, err set
        idle();
        wb_we = 1; wb_addr = 11; wb_data = 32'h11111111;
        step();
        idle();
        re1 = 1; raddr1 = 11;
        settle();
        chk("udf_err", {31'b0, err}, 32'h1);
        chk("udf_data", rdata1, 32'h11111111);

        // mid-stream reset clears counters, err and registers
        idle();
        issue_we = 1; issue_addr = 12;
        step();
        issue_we = 0;
        re1 = 1; raddr1 = 12;
        settle();
        chk("mid_pend", {31'b0, stall}, 32'h1);
        rst = 0;
        settle();
        chk("mid_err", {31'b0, err}, 32'h0);
        chk("mid_stall", {31'b0, stall}, 32'h0);
        step();
        rst = 1;
        settle();
        chk("mid_cnt", {31'b0, stall}, 32'h0);
        raddr1 = 11;
        settle();
        chk("mid_regs", rdata1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
